// File: rtl/pixel_array_seq.sv
// Pixel array phase sequencer with a Wishbone register slave.
// Each enabled channel is walked through reset, integrate, adjust and read
// phases in ascending channel order; a frame ends after the highest enabled
// channel, optionally restarting in continuous mode.
// Optional build macro PXL_SEQ_IRQ_EN: frame-end interrupt at offset 0x10.
// With the macro undefined the IRQ register reads 0 and irq_o is tied low.
module pixel_array_seq #(
    parameter int          NPIX     = 4,
    parameter int          TW       = 10,
    parameter logic [3:0]  BASE_NIB = 4'h3
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    input  logic            wbs_cyc_i,
    input  logic            wbs_stb_i,
    input  logic            wbs_we_i,
    input  logic [3:0]      wbs_sel_i,
    input  logic [31:0]     wbs_adr_i,
    input  logic [31:0]     wbs_dat_i,
    output logic            wbs_ack_o,
    output logic [31:0]     wbs_dat_o,
    input  logic            pxl_start_i,
    output logic [NPIX-1:0] pxl_rst_o,
    output logic [NPIX-1:0] pxl_int_o,
    output logic [NPIX-1:0] pxl_adj_o,
    output logic [NPIX-1:0] pxl_rd_o,
    output logic            pxl_done_o,
    output logic            irq_o
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RST  = 3'd1,
        ST_INT  = 3'd2,
        ST_ADJ  = 3'd3,
        ST_RD   = 3'd4,
        ST_NEXT = 3'd5
    } state_t;

    localparam logic [8:0]    MASK_ALL   = (9'd1 << NPIX) - 9'd1;
    localparam logic [7:0]    VALID_MASK = MASK_ALL[7:0];
    localparam logic [TW-1:0] CNT_ZERO   = {TW{1'b0}};
    localparam logic [TW-1:0] CNT_ONE    = {{(TW-1){1'b0}}, 1'b1};

    // Lowest set bit of mask at index >= lo, returned as {found, index}.
    function automatic logic [3:0] pick_ch(input logic [7:0] mask, input logic [3:0] lo);
        logic [3:0] res;
        res = 4'd0;
        for (int i = 7; i >= 0; i--) begin
            if (mask[i] && (4'(i) >= lo)) begin
                res = {1'b1, 3'(i)};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Bus-side registers
    logic            ack_q;
    logic [31:0]     dat_q;
    logic [7:0]      mask_q;
    logic            cont_q;
    logic [TW-1:0]   loc_max_q;
    logic [TW-1:0]   adj_max_q;

    // Sequencer state
    state_t          state_q, state_d;
    logic [2:0]      ch_q, ch_d;
    logic [TW-1:0]   cnt_q, cnt_d;
    logic [TW-1:0]   lim_q, lim_d;
    logic [7:0]      done_mask_q, done_mask_d;
    logic            frame_end_s;

    // Registered phase strobes
    logic [NPIX-1:0] rst_q, int_q, adj_q, rd_q;
    logic [NPIX-1:0] rst_d, int_d, adj_d, rd_d, onehot_s;
    logic            done_q, done_d;

    // Bus decode
    logic            hit_s, acc_s, wr_s, wr_ctrl_s;
    logic [2:0]      off_s;
    logic            start_s, abort_s, busy_s, irq_bit_s;
    logic [7:0]      mask_eff_s;
    logic [2:0]      act_ch_s;
    logic [31:0]     rd_data_s;
    logic [3:0]      first_s, next_s, restart_s;
    logic            unused_s;

    assign hit_s      = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:28] == BASE_NIB);
    // A hit arriving while the previous ack is still up is held off one cycle.
    assign acc_s      = hit_s & ~ack_q;
    assign wr_s       = acc_s & wbs_we_i & wbs_sel_i[0];
    assign off_s      = wbs_adr_i[4:2];
    assign wr_ctrl_s  = wr_s & (off_s == 3'd0);
    assign start_s    = (wr_ctrl_s & wbs_dat_i[0]) | pxl_start_i;
    assign abort_s    = wr_ctrl_s & wbs_dat_i[2];
    // A CTRL write carrying start uses the mask it writes.
    assign mask_eff_s = wr_ctrl_s ? (wbs_dat_i[15:8] & VALID_MASK) : mask_q;
    assign busy_s     = (state_q != ST_IDLE);
    assign act_ch_s   = busy_s ? ch_q : 3'd0;
    assign unused_s   = ^{wbs_adr_i[27:5], wbs_adr_i[1:0], wbs_sel_i[3:1], wbs_dat_i[31:16]};

    // Read data multiplexer for the addressed register
    always_comb begin
        rd_data_s = 32'd0;
        case (off_s)
            3'd0:    rd_data_s = {16'd0, mask_q, 5'd0, 1'b0, cont_q, 1'b0};
            3'd1:    rd_data_s = 32'(loc_max_q);
            3'd2:    rd_data_s = 32'(adj_max_q);
            3'd3:    rd_data_s = {8'd0, 5'd0, act_ch_s, done_mask_q, 7'd0, busy_s};
            3'd4:    rd_data_s = {31'd0, irq_bit_s};
            default: rd_data_s = 32'd0;
        endcase
    end

    // Wishbone ack/data and writable configuration registers
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            ack_q     <= 1'b0;
            dat_q     <= 32'd0;
            mask_q    <= 8'd0;
            cont_q    <= 1'b0;
            loc_max_q <= CNT_ZERO;
            adj_max_q <= CNT_ZERO;
        end else begin
            ack_q <= acc_s;
            if (acc_s) begin
                dat_q <= rd_data_s;
            end else begin
                dat_q <= 32'd0;
            end
            if (wr_ctrl_s) begin
                mask_q <= wbs_dat_i[15:8] & VALID_MASK;
                cont_q <= wbs_dat_i[1];
            end
            if (wr_s && (off_s == 3'd1)) begin
                loc_max_q <= wbs_dat_i[TW-1:0];
            end
            if (wr_s && (off_s == 3'd2)) begin
                adj_max_q <= wbs_dat_i[TW-1:0];
            end
        end
    end

    // Sequencer state register
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            state_q     <= ST_IDLE;
            ch_q        <= 3'd0;
            cnt_q       <= CNT_ZERO;
            lim_q       <= CNT_ZERO;
            done_mask_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            cnt_q       <= cnt_d;
            lim_q       <= lim_d;
            done_mask_q <= done_mask_d;
        end
    end

    // Sequencer next-state logic
    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        cnt_d       = cnt_q;
        lim_d       = lim_q;
        done_mask_d = done_mask_q;
        frame_end_s = 1'b0;
        first_s     = pick_ch(mask_eff_s, 4'd0);
        next_s      = pick_ch(mask_q, {1'b0, ch_q} + 4'd1);
        restart_s   = pick_ch(mask_q, 4'd0);
        if (abort_s && busy_s) begin
            state_d = ST_IDLE;
            cnt_d   = CNT_ZERO;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_s && !abort_s && first_s[3]) begin
                        state_d     = ST_RST;
                        ch_d        = first_s[2:0];
                        cnt_d       = CNT_ZERO;
                        done_mask_d = 8'd0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_RST: begin
                    if (cnt_q == CNT_ONE) begin
                        state_d = ST_INT;
                        cnt_d   = CNT_ZERO;
                        lim_d   = loc_max_q;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                ST_INT: begin
                    if (cnt_q == lim_q) begin
                        state_d = ST_ADJ;
                        cnt_d   = CNT_ZERO;
                        lim_d   = adj_max_q;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                ST_ADJ: begin
                    if (cnt_q == lim_q) begin
                        state_d = ST_RD;
                        cnt_d   = CNT_ZERO;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                ST_RD: begin
                    state_d     = ST_NEXT;
                    done_mask_d = done_mask_q | (8'd1 << ch_q);
                end
                ST_NEXT: begin
                    cnt_d = CNT_ZERO;
                    if (next_s[3]) begin
                        state_d = ST_RST;
                        ch_d    = next_s[2:0];
                    end else begin
                        frame_end_s = 1'b1;
                        if (cont_q && restart_s[3]) begin
                            state_d     = ST_RST;
                            ch_d        = restart_s[2:0];
                            done_mask_d = 8'd0;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = CNT_ZERO;
                end
            endcase
        end
    end

    // Strobe decode from the upcoming state so registered strobes track the state
    always_comb begin
        onehot_s = {NPIX{1'b0}};
        for (int i = 0; i < NPIX; i++) begin
            if (ch_d == 3'(i)) begin
                onehot_s[i] = 1'b1;
            end else begin
                onehot_s[i] = 1'b0;
            end
        end
        rst_d  = {NPIX{1'b0}};
        int_d  = {NPIX{1'b0}};
        adj_d  = {NPIX{1'b0}};
        rd_d   = {NPIX{1'b0}};
        case (state_d)
            ST_RST:  rst_d = onehot_s;
            ST_INT:  int_d = onehot_s;
            ST_ADJ:  adj_d = onehot_s;
            ST_RD:   rd_d  = onehot_s;
            default: rst_d = {NPIX{1'b0}};
        endcase
        done_d = frame_end_s;
    end

    // Output strobe and frame-done registers
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            rst_q  <= {NPIX{1'b0}};
            int_q  <= {NPIX{1'b0}};
            adj_q  <= {NPIX{1'b0}};
            rd_q   <= {NPIX{1'b0}};
            done_q <= 1'b0;
        end else begin
            rst_q  <= rst_d;
            int_q  <= int_d;
            adj_q  <= adj_d;
            rd_q   <= rd_d;
            done_q <= done_d;
        end
    end

`ifdef PXL_SEQ_IRQ_EN
    logic irq_q;

    // Frame-end interrupt latch; a new frame end beats a same-cycle clear
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            irq_q <= 1'b0;
        end else if (frame_end_s) begin
            irq_q <= 1'b1;
        end else if (wr_s && (off_s == 3'd4) && wbs_dat_i[0]) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_q;
        end
    end

    assign irq_bit_s = irq_q;
`else
    assign irq_bit_s = 1'b0;
`endif

    assign wbs_ack_o  = ack_q;
    assign wbs_dat_o  = dat_q;
    assign pxl_rst_o  = rst_q;
    assign pxl_int_o  = int_q;
    assign pxl_adj_o  = adj_q;
    assign pxl_rd_o   = rd_q;
    assign pxl_done_o = done_q;
    assign irq_o      = irq_bit_s;

endmodule

// File: tb/tb_pixel_array_seq.sv
// Directed bench for pixel_array_seq (NPIX=4, TW=10, BASE_NIB=3).
module tb_pixel_array_seq;

    localparam logic [31:0] A_CTRL = 32'h3000_0000;
    localparam logic [31:0] A_LOC  = 32'h3000_0004;
    localparam logic [31:0] A_ADJ  = 32'h3000_0008;
    localparam logic [31:0] A_STAT = 32'h3000_000C;
    localparam logic [31:0] A_IRQ  = 32'h3000_0010;
    localparam logic [31:0] A_UNDF = 32'h3000_0014;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i;
    logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i, wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic        pxl_start_i;
    logic [3:0]  pxl_rst_o, pxl_int_o, pxl_adj_o, pxl_rd_o;
    logic        pxl_done_o;
    logic        irq_o;

    int checks   = 0;
    int failures = 0;

    int rst_cnt [4] = '{0, 0, 0, 0};
    int int_cnt [4] = '{0, 0, 0, 0};
    int adj_cnt [4] = '{0, 0, 0, 0};
    int rd_cnt  [4] = '{0, 0, 0, 0};
    int done_cnt  = 0;
    int multi_cnt = 0;

    pixel_array_seq #(.NPIX(4), .TW(10), .BASE_NIB(4'h3)) dut (
        .wb_clk_i   (wb_clk_i),
        .wb_rst_i   (wb_rst_i),
        .wbs_cyc_i  (wbs_cyc_i),
        .wbs_stb_i  (wbs_stb_i),
        .wbs_we_i   (wbs_we_i),
        .wbs_sel_i  (wbs_sel_i),
        .wbs_adr_i  (wbs_adr_i),
        .wbs_dat_i  (wbs_dat_i),
        .wbs_ack_o  (wbs_ack_o),
        .wbs_dat_o  (wbs_dat_o),
        .pxl_start_i(pxl_start_i),
        .pxl_rst_o  (pxl_rst_o),
        .pxl_int_o  (pxl_int_o),
        .pxl_adj_o  (pxl_adj_o),
        .pxl_rd_o   (pxl_rd_o),
        .pxl_done_o (pxl_done_o),
        .irq_o      (irq_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    // Strobe activity monitor sampled mid-cycle
    always @(negedge wb_clk_i) begin
        for (int c = 0; c < 4; c++) begin
            if (pxl_rst_o[c]) rst_cnt[c]++;
            if (pxl_int_o[c]) int_cnt[c]++;
            if (pxl_adj_o[c]) adj_cnt[c]++;
            if (pxl_rd_o[c])  rd_cnt[c]++;
        end
        if ($countones({pxl_rst_o, pxl_int_o, pxl_adj_o, pxl_rd_o}) > 1) multi_cnt++;
        if (pxl_done_o) done_cnt++;
    end

    function automatic int total_strobes();
        int t;
        t = 0;
        for (int c = 0; c < 4; c++) t += rst_cnt[c] + int_cnt[c] + adj_cnt[c] + rd_cnt[c];
        return t;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        @(negedge wb_clk_i);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1;
        wbs_sel_i = sel;  wbs_adr_i = adr;  wbs_dat_i = dat;
        @(posedge wb_clk_i); #1;
        chk("wr_ack", {31'd0, wbs_ack_o}, 32'd1);
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0; wbs_sel_i = 4'h0;
        @(posedge wb_clk_i); #1;
    endtask

    task automatic wb_read(input logic [31:0] adr, output logic [31:0] dat);
        @(negedge wb_clk_i);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0;
        wbs_sel_i = 4'hF; wbs_adr_i = adr;
        @(posedge wb_clk_i); #1;
        chk("rd_ack", {31'd0, wbs_ack_o}, 32'd1);
        dat = wbs_dat_o;
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        @(posedge wb_clk_i); #1;
    endtask

    task automatic wait_idle(input string tag);
        logic [31:0] st;
        bit          ok;
        ok = 1'b0;
        for (int n = 0; n < 100; n++) begin
            wb_read(A_STAT, st);
            if (st[0] == 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        chk(tag, {31'd0, ok}, 32'd1);
    endtask

    initial begin
        logic [31:0] rd;
        int b_rst [4], b_int [4], b_adj [4], b_rd [4];
        int b_done, b_tot;
        bit found;

        wb_rst_i = 1'b0; wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
        wbs_sel_i = 4'h0; wbs_adr_i = 32'd0; wbs_dat_i = 32'd0; pxl_start_i = 1'b0;
        repeat (3) @(negedge wb_clk_i);

        // Reset state
        chk("rst_ack", {31'd0, wbs_ack_o}, 32'd0);
        chk("rst_dat", wbs_dat_o, 32'd0);
        chk("rst_strobes", {16'd0, pxl_rst_o, pxl_int_o, pxl_adj_o, pxl_rd_o}, 32'd0);
        chk("rst_done", {31'd0, pxl_done_o}, 32'd0);
        chk("rst_irq", {31'd0, irq_o}, 32'd0);
        wb_rst_i = 1'b1;
        wb_read(A_STAT, rd); chk("rst_status", rd, 32'd0);
        wb_read(A_CTRL, rd); chk("rst_ctrl", rd, 32'd0);

        // Mask bits above NPIX are dropped; sel[0]=0 blocks a write
        wb_write(A_CTRL, 32'h0000_FF00, 4'hF);
        wb_read(A_CTRL, rd); chk("ctrl_mask_trim", rd, 32'h0000_0F00);
        wb_write(A_CTRL, 32'h0000_0000, 4'hF);
        wb_write(A_LOC, 32'd3, 4'hF);
        wb_write(A_LOC, 32'd7, 4'hE);
        wb_read(A_LOC, rd); chk("loc_sel0_block", rd, 32'd3);
        wb_write(A_ADJ, 32'd1, 4'hF);
        wb_read(A_ADJ, rd); chk("adj_max", rd, 32'd1);

        // Frame over channels 0 and 2
        wb_write(A_CTRL, 32'h0000_0500, 4'hF);
        b_rst = rst_cnt; b_int = int_cnt; b_adj = adj_cnt; b_rd = rd_cnt; b_done = done_cnt;
        wb_write(A_CTRL, 32'h0000_0501, 4'hF);
        wb_read(A_STAT, rd); chk("status_busy_ch0", rd, 32'h0000_0001);
        wait_idle("frame05_idle");
        chk("ch0_rst", 32'(rst_cnt[0] - b_rst[0]), 32'd2);
        chk("ch0_int", 32'(int_cnt[0] - b_int[0]), 32'd4);
        chk("ch0_adj", 32'(adj_cnt[0] - b_adj[0]), 32'd2);
        chk("ch0_rd",  32'(rd_cnt[0]  - b_rd[0]),  32'd1);
        chk("ch2_rst", 32'(rst_cnt[2] - b_rst[2]), 32'd2);
        chk("ch2_int", 32'(int_cnt[2] - b_int[2]), 32'd4);
        chk("ch2_adj", 32'(adj_cnt[2] - b_adj[2]), 32'd2);
        chk("ch2_rd",  32'(rd_cnt[2]  - b_rd[2]),  32'd1);
        chk("ch1_ch3_quiet", 32'(rst_cnt[1] + rst_cnt[3] + int_cnt[1] + int_cnt[3]
                                 - b_rst[1] - b_rst[3] - b_int[1] - b_int[3]), 32'd0);
        chk("frame05_done", 32'(done_cnt - b_done), 32'd1);
        wb_read(A_STAT, rd); chk("status_done05", rd, 32'h0000_0500);
`ifdef PXL_SEQ_IRQ_EN
        chk("irq_set", {31'd0, irq_o}, 32'd1);
        wb_write(A_IRQ, 32'd1, 4'hF);
        chk("irq_clr", {31'd0, irq_o}, 32'd0);
`else
        chk("irq_off", {31'd0, irq_o}, 32'd0);
        wb_write(A_IRQ, 32'd1, 4'hF);
        wb_read(A_IRQ, rd); chk("irq_reg_off", rd, 32'd0);
`endif

        // Start with empty mask is ignored
        b_tot = total_strobes();
        wb_write(A_CTRL, 32'h0000_0001, 4'hF);
        @(negedge wb_clk_i); pxl_start_i = 1'b1;
        @(negedge wb_clk_i); pxl_start_i = 1'b0;
        repeat (5) @(negedge wb_clk_i);
        chk("mask0_no_strobe", 32'(total_strobes() - b_tot), 32'd0);
        wb_read(A_STAT, rd); chk("mask0_status", rd, 32'h0000_0500);

        // External start, channel 1; start write mid-frame ignored
        wb_write(A_CTRL, 32'h0000_0200, 4'hF);
        b_rst = rst_cnt; b_int = int_cnt; b_adj = adj_cnt; b_rd = rd_cnt; b_done = done_cnt;
        @(negedge wb_clk_i); pxl_start_i = 1'b1;
        @(negedge wb_clk_i); pxl_start_i = 1'b0;
        repeat (3) @(negedge wb_clk_i);
        wb_write(A_CTRL, 32'h0000_0201, 4'hF);
        wait_idle("frame02_idle");
        chk("ch1_rst", 32'(rst_cnt[1] - b_rst[1]), 32'd2);
        chk("ch1_int", 32'(int_cnt[1] - b_int[1]), 32'd4);
        chk("ch1_adj", 32'(adj_cnt[1] - b_adj[1]), 32'd2);
        chk("ch1_rd",  32'(rd_cnt[1]  - b_rd[1]),  32'd1);
        chk("frame02_done", 32'(done_cnt - b_done), 32'd1);
        wb_read(A_STAT, rd); chk("status_done02", rd, 32'h0000_0200);

        // Abort during ch2 adjust keeps done mask of ch0
        b_rd = rd_cnt; b_done = done_cnt;
        wb_write(A_CTRL, 32'h0000_0501, 4'hF);
        found = 1'b0;
        for (int n = 0; n < 60; n++) begin
            @(negedge wb_clk_i);
            if (pxl_adj_o[2]) begin
                found = 1'b1;
                break;
            end
        end
        chk("wait_adj2", {31'd0, found}, 32'd1);
        wb_write(A_CTRL, 32'h0000_0504, 4'hF);
        chk("abort_strobes", {16'd0, pxl_rst_o, pxl_int_o, pxl_adj_o, pxl_rd_o}, 32'd0);
        repeat (3) @(negedge wb_clk_i);
        wb_read(A_STAT, rd); chk("abort_status", rd, 32'h0000_0100);
        chk("abort_no_done", 32'(done_cnt - b_done), 32'd0);
        chk("abort_no_rd2", 32'(rd_cnt[2] - b_rd[2]), 32'd0);

        // Continuous mode on ch3, then abort during integrate
        wb_write(A_CTRL, 32'h0000_0802, 4'hF);
        b_done = done_cnt;
        wb_write(A_CTRL, 32'h0000_0803, 4'hF);
        repeat (25) @(negedge wb_clk_i);
        chk("cont_repeats", {31'd0, (done_cnt - b_done) >= 2}, 32'd1);
        found = 1'b0;
        for (int n = 0; n < 30; n++) begin
            @(negedge wb_clk_i);
            if (pxl_int_o[3]) begin
                found = 1'b1;
                break;
            end
        end
        chk("wait_int3", {31'd0, found}, 32'd1);
        b_done = done_cnt;
        wb_write(A_CTRL, 32'h0000_0806, 4'hF);
        chk("cont_abort_strobes", {16'd0, pxl_rst_o, pxl_int_o, pxl_adj_o, pxl_rd_o}, 32'd0);
        b_tot = total_strobes();
        repeat (10) @(negedge wb_clk_i);
        chk("cont_abort_quiet", 32'(total_strobes() - b_tot), 32'd0);
        chk("cont_abort_no_done", 32'(done_cnt - b_done), 32'd0);
        wb_read(A_STAT, rd); chk("cont_abort_busy", {31'd0, rd[0]}, 32'd0);

        // Undefined offset, address miss, back-to-back strobes
        wb_read(A_UNDF, rd); chk("undef_read", rd, 32'd0);
        @(negedge wb_clk_i);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = 32'h2000_0004;
        for (int n = 0; n < 3; n++) begin
            @(posedge wb_clk_i); #1;
            chk("miss_no_ack", {31'd0, wbs_ack_o}, 32'd0);
        end
        wbs_adr_i = A_LOC;
        for (int n = 0; n < 6; n++) begin
            @(posedge wb_clk_i); #1;
            chk("b2b_ack", {31'd0, wbs_ack_o}, (n % 2 == 0) ? 32'd1 : 32'd0);
            if (wbs_ack_o) chk("b2b_dat", wbs_dat_o, 32'd3);
        end
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        @(posedge wb_clk_i); #1;

        // Reset mid-frame abandons the frame
        wb_write(A_CTRL, 32'h0000_0101, 4'hF);
        repeat (4) @(negedge wb_clk_i);
        b_done = done_cnt;
        wb_rst_i = 1'b0;
        @(negedge wb_clk_i);
        chk("midrst_strobes", {16'd0, pxl_rst_o, pxl_int_o, pxl_adj_o, pxl_rd_o}, 32'd0);
        wb_rst_i = 1'b1;
        repeat (20) @(negedge wb_clk_i);
        chk("midrst_no_done", 32'(done_cnt - b_done), 32'd0);
        wb_read(A_STAT, rd); chk("midrst_status", rd, 32'd0);
        wb_read(A_LOC, rd);  chk("midrst_loc", rd, 32'd0);

        chk("strobe_exclusive", 32'(multi_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
